// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for a dual-clock gray-pointer FIFO.
// Define FIFO_RD_LEVEL_EN to build the fill-level and almost-empty logic.
module fifo_rd_ctrl #(
  parameter int AW        = 4,
  parameter int AE_THRESH = 2
) (
  input  logic          I_RD_CLK,
  input  logic          I_RD_RST_N,
  input  logic          I_RD_EN,
  input  logic [AW:0]   I_RD_WR_PTR,
  input  logic          I_RD_UFLOW_CLR,
  output logic [AW-1:0] O_RD_ADDR,
  output logic [AW:0]   O_RD_PTR,
  output logic          O_RD_EMPTY,
  output logic [AW:0]   O_RD_LEVEL,
  output logic          O_RD_AEMPTY,
  output logic          O_RD_UFLOW
);

  logic [AW:0] wsync1_q, wsync2_q;
  logic [AW:0] rd_bin_q, rd_bin_d;
  logic [AW:0] rd_gray_q, rd_gray_d;
  logic        empty_q, empty_d;
  logic        uflow_q, uflow_d;
  logic        rd_inc;

  // NOTE: every signal gets a value before any condition, so no latch is inferred.
  always_comb begin
    rd_inc    = I_RD_EN & ~empty_q;
    rd_bin_d  = rd_bin_q + {{AW{1'b0}}, rd_inc};
    rd_gray_d = (rd_bin_d >> 1) ^ rd_bin_d;
    empty_d   = (rd_gray_d == wsync2_q);
    uflow_d   = uflow_q;
    if (I_RD_EN && empty_q) begin
      uflow_d = 1'b1;
    end else if (I_RD_UFLOW_CLR) begin
      uflow_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so the two synchroniser stages shift, not collapse.
  always_ff @(posedge I_RD_CLK or negedge I_RD_RST_N) begin
    if (!I_RD_RST_N) begin
      wsync1_q  <= '0;
      wsync2_q  <= '0;
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      empty_q   <= 1'b1;
      uflow_q   <= 1'b0;
    end else begin
      wsync1_q  <= I_RD_WR_PTR;
      wsync2_q  <= wsync1_q;
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      empty_q   <= empty_d;
      uflow_q   <= uflow_d;
    end
  end

  assign O_RD_ADDR  = rd_bin_q[AW-1:0];
  assign O_RD_PTR   = rd_gray_q;
  assign O_RD_EMPTY = empty_q;
  assign O_RD_UFLOW = uflow_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0] wbin;
  logic [AW:0] level_d, level_q;
  logic        aempty_d, aempty_q;

  // Level uses the synchronised write pointer, so it can only under-report.
  always_comb begin
    wbin[AW] = wsync2_q[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ wsync2_q[i];
    end
    level_d  = wbin - rd_bin_d;
    aempty_d = (level_d <= (AW+1)'(AE_THRESH));
  end

  always_ff @(posedge I_RD_CLK or negedge I_RD_RST_N) begin
    if (!I_RD_RST_N) begin
      level_q  <= '0;
      aempty_q <= 1'b1;
    end else begin
      level_q  <= level_d;
      aempty_q <= aempty_d;
    end
  end

  assign O_RD_LEVEL  = level_q;
  assign O_RD_AEMPTY = aempty_q;
`else
  assign O_RD_LEVEL  = '0;
  assign O_RD_AEMPTY = empty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl; expectations come from a count-based model.
module tb_fifo_rd_ctrl;

  localparam int AW  = 4;
  localparam int AET = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic          uflow_clr = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr;
  logic          rd_empty;
  logic [AW:0]   rd_level;
  logic          rd_aempty;
  logic          rd_uflow;

  fifo_rd_ctrl #(.AW(AW), .AE_THRESH(AET)) dut (
    .I_RD_CLK       (clk),
    .I_RD_RST_N     (rst_n),
    .I_RD_EN        (rd_en),
    .I_RD_WR_PTR    (wr_ptr),
    .I_RD_UFLOW_CLR (uflow_clr),
    .O_RD_ADDR      (rd_addr),
    .O_RD_PTR       (rd_ptr),
    .O_RD_EMPTY     (rd_empty),
    .O_RD_LEVEL     (rd_level),
    .O_RD_AEMPTY    (rd_aempty),
    .O_RD_UFLOW     (rd_uflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   ptr;
    logic          empty;
    logic [AW:0]   level;
    logic          aempty;
    logic          uflow;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: plain binary counts modulo 32 and a two-stage delay of the write count.
  int m_wr, m_s1, m_s2, m_rd;
  bit m_empty, m_uflow;

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_s1 = 0; m_s2 = 0; m_rd = 0;
    m_empty = 1'b1; m_uflow = 1'b0;
  endtask

  task automatic sb_step(input bit en, input bit clr, input string tag);
    exp_t e;
    int   rd_n, lvl;
    bit   read_ok;
    @(negedge clk);
    rd_en     = en;
    uflow_clr = clr;
    wr_ptr    = gray(m_wr);
    read_ok   = en && !m_empty;
    rd_n      = (m_rd + (read_ok ? 1 : 0)) % 32;
    lvl       = (m_s2 - rd_n + 32) % 32;
    e.addr    = rd_n[AW-1:0];
    e.ptr     = gray(rd_n);
    e.empty   = (lvl == 0);
`ifdef FIFO_RD_LEVEL_EN
    e.level   = lvl[AW:0];
    e.aempty  = (lvl <= AET);
`else
    e.level   = '0;
    e.aempty  = (lvl == 0);
`endif
    e.uflow   = (en && m_empty) ? 1'b1 : (clr ? 1'b0 : m_uflow);
    sb.push_back(e);
    m_s2 = m_s1; m_s1 = m_wr; m_rd = rd_n; m_empty = e.empty; m_uflow = e.uflow;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_checks += 6;
    if (rd_addr !== e.addr) begin
      n_errors++; $display("FAIL %s addr: got %0d want %0d", tag, rd_addr, e.addr);
    end
    if (rd_ptr !== e.ptr) begin
      n_errors++; $display("FAIL %s ptr: got %b want %b", tag, rd_ptr, e.ptr);
    end
    if (rd_empty !== e.empty) begin
      n_errors++; $display("FAIL %s empty: got %b want %b", tag, rd_empty, e.empty);
    end
    if (rd_level !== e.level) begin
      n_errors++; $display("FAIL %s level: got %0d want %0d", tag, rd_level, e.level);
    end
    if (rd_aempty !== e.aempty) begin
      n_errors++; $display("FAIL %s aempty: got %b want %b", tag, rd_aempty, e.aempty);
    end
    if (rd_uflow !== e.uflow) begin
      n_errors++; $display("FAIL %s uflow: got %b want %b", tag, rd_uflow, e.uflow);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (rd_addr !== '0 || rd_ptr !== '0 || rd_empty !== 1'b1 || rd_level !== '0 ||
        rd_aempty !== 1'b1 || rd_uflow !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got addr=%0d ptr=%b empty=%b level=%0d aempty=%b uflow=%b want 0,0,1,0,1,0",
               tag, rd_addr, rd_ptr, rd_empty, rd_level, rd_aempty, rd_uflow);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    #1;
    check_reset_values("reset_released");
    sb_step(1'b0, 1'b0, "reset_idle");
  endtask

  task automatic test_empty_deassert();
    m_wr = 3;
    sb_step(1'b0, 1'b0, "deassert_e1");
    n_checks++;
    if (rd_empty !== 1'b1) begin
      n_errors++; $display("FAIL deassert_edge1 empty: got %b want 1", rd_empty);
    end
    sb_step(1'b0, 1'b0, "deassert_e2");
    n_checks++;
    if (rd_empty !== 1'b1) begin
      n_errors++; $display("FAIL deassert_edge2 empty: got %b want 1", rd_empty);
    end
    sb_step(1'b0, 1'b0, "deassert_e3");
    n_checks++;
    if (rd_empty !== 1'b0) begin
      n_errors++; $display("FAIL deassert_edge3 empty: got %b want 0", rd_empty);
    end
`ifdef FIFO_RD_LEVEL_EN
    n_checks++;
    if (rd_level !== 5'd3 || rd_aempty !== 1'b0) begin
      n_errors++;
      $display("FAIL deassert_edge3 level/aempty: got %0d/%b want 3/0", rd_level, rd_aempty);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++) sb_step(1'b1, 1'b0, "drain");
    n_checks++;
    if (rd_ptr !== 5'b00010 || rd_empty !== 1'b1 || rd_addr !== 4'd3) begin
      n_errors++;
      $display("FAIL drain_end: got ptr=%b empty=%b addr=%0d want 00010,1,3", rd_ptr, rd_empty, rd_addr);
    end
  endtask

  task automatic test_underflow();
    sb_step(1'b1, 1'b0, "uflow_set");
    n_checks++;
    if (rd_addr !== 4'd3 || rd_uflow !== 1'b1) begin
      n_errors++; $display("FAIL uflow_set: got addr=%0d uflow=%b want 3,1", rd_addr, rd_uflow);
    end
    sb_step(1'b0, 1'b1, "uflow_clr");
    sb_step(1'b1, 1'b1, "uflow_set_wins");
    n_checks++;
    if (rd_uflow !== 1'b1) begin
      n_errors++; $display("FAIL uflow_set_wins: got %b want 1", rd_uflow);
    end
    sb_step(1'b0, 1'b1, "uflow_clr2");
  endtask

  task automatic test_wrap();
    logic [AW:0]   prev_ptr;
    logic [AW-1:0] prev_addr;
    bit            addr_wrapped;
    addr_wrapped = 1'b0;
    prev_ptr     = rd_ptr;
    prev_addr    = rd_addr;
    for (int i = 0; i < 46; i++) begin
      if (i < 40) m_wr = (m_wr + 1) % 32;
      sb_step(1'b1, 1'b0, "wrap");
      if (prev_addr == 4'd15 && rd_addr == 4'd0) addr_wrapped = 1'b1;
      n_checks += 2;
      if ($countones(rd_ptr ^ prev_ptr) > 1) begin
        n_errors++; $display("FAIL wrap_gray_step: got %b after %b want <=1 bit change", rd_ptr, prev_ptr);
      end
      if (rd_level > 5'd16) begin
        n_errors++; $display("FAIL wrap_level_bound: got %0d want <=16", rd_level);
      end
      prev_ptr  = rd_ptr;
      prev_addr = rd_addr;
    end
    n_checks++;
    if (!addr_wrapped) begin
      n_errors++; $display("FAIL wrap_addr: got no 15->0 transition want one");
    end
    sb_step(1'b0, 1'b1, "wrap_clr");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      m_wr = (m_wr + 1) % 32;
      sb_step(1'b0, 1'b0, "fill");
    end
    for (int i = 0; i < 3; i++) sb_step(1'b0, 1'b0, "fill_sync");
    n_checks++;
`ifdef FIFO_RD_LEVEL_EN
    if (rd_level !== 5'd16) begin
      n_errors++; $display("FAIL full_level: got %0d want 16", rd_level);
    end
`else
    if (rd_level !== 5'd0 || rd_aempty !== rd_empty) begin
      n_errors++; $display("FAIL full_nolevel: got level=%0d aempty=%b want 0,%b", rd_level, rd_aempty, rd_empty);
    end
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 9; i++) sb_step(1'b1, 1'b0, "to_level7");
    n_checks++;
    if (rd_empty !== 1'b0) begin
      n_errors++; $display("FAIL pre_reset empty: got %b want 0", rd_empty);
    end
    #2;
    rst_n  = 1'b0;
    rd_en  = 1'b0;
    wr_ptr = '0;
    #1;
    check_reset_values("mid_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 5;
    for (int i = 0; i < 3; i++) sb_step(1'b0, 1'b0, "post_reset_sync");
    for (int i = 0; i < 2; i++) sb_step(1'b1, 1'b0, "post_reset_read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_empty_deassert();
    test_drain();
    test_underflow();
    test_wrap();
    test_full();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
